mem_arbiter: RTL and testbench

Parametrised N-channel memory-port arbiter. It merges the CPU's request/ready cache ports (icache, dcache, and future masters such as a DMA or debug port) onto one backing memory port. Arbitration is round-robin or fixed-priority. One transaction is outstanding at a time. It sits between `cpu` and the shared memory or L2 model, and it exposes the same req/rdy handshake on both sides.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port arbiter: write-size codes,
// FSM state type and a small index helper.
package mem_pkg;

  // Write-size encoding carried on ch_ws / mem_ws (passed through untouched).
  localparam logic [1:0] WS_BYTE = 2'd0;
  localparam logic [1:0] WS_HALF = 2'd1;
  localparam logic [1:0] WS_WORD = 2'd2;

  // Arbiter FSM: wait for a request, own the memory port, pulse completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Next channel index with wrap-around at n (used for the round-robin pointer).
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker. Scans the request vector upward from a
// start index, wrapping at NCH, and reports the first set bit. In fixed
// priority mode the scan always starts at 0, so the lowest index wins.
module rr_pick #(
  parameter int NCH = 2,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  input  logic           i_fixed,
  output logic [PW-1:0]  o_idx,
  output logic           o_found
);

  // Wrapped priority scan starting at the pointer (or at 0 in fixed mode).
  always_comb begin
    int start;
    int cand;
    // NOTE: every output gets a default before the loop so no path leaves
    // them unassigned; otherwise synthesis would infer latches.
    o_idx   = '0;
    o_found = 1'b0;
    start   = 0;
    cand    = 0;
    if (!i_fixed && (int'(i_ptr) < NCH)) begin
      start = int'(i_ptr);
    end
    for (int off = 0; off < NCH; off++) begin
      cand = start + off;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      if (!o_found && i_req[cand]) begin
        o_found = 1'b1;
        o_idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory-port arbiter. Merges several req/rdy masters onto one
// backing memory port with a single outstanding transaction. The winning
// channel's fields are latched in IDLE, presented downstream in MEM, and
// the completion is returned as a one-cycle rdy pulse in RESP.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter  int NCH        = 2,
  parameter  int AW         = 32,
  parameter  int DW         = 32,
  parameter  int FIXED_PRIO = 0,
  localparam int GW         = $clog2(NCH)
) (
  input  logic            clock,
  input  logic            reset,
  // Upstream channels
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH*2-1:0]  ch_ws,
  output logic [DW-1:0]     ch_rdata,
  output logic [NCH-1:0]    ch_rdy,
  // Downstream memory port
  output logic              mem_req,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [1:0]        mem_ws,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_rdy,
  // Status
  output logic [GW-1:0]     grant_id,
  output logic              busy
);

  arb_state_t      r_state;
  logic [GW-1:0]   r_ptr;

  logic [GW-1:0]   w_idx;
  logic            w_found;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [1:0]      w_sel_ws;
  logic            w_sel_wr;

  // Winner selection; the pointer only matters in round-robin mode.
  rr_pick #(
    .NCH (NCH),
    .PW  (GW)
  ) u_pick (
    .i_req   (ch_req),
    .i_ptr   (r_ptr),
    .i_fixed (FIXED_PRIO != 0),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // Fields of the candidate winner, sliced out of the packed channel buses.
  assign w_sel_addr  = ch_addr [int'(w_idx)*AW +: AW];
  assign w_sel_wdata = ch_wdata[int'(w_idx)*DW +: DW];
  assign w_sel_ws    = ch_ws   [int'(w_idx)*2  +: 2];
  assign w_sel_wr    = ch_wr   [w_idx];

  // Arbiter FSM with all outputs registered; reset abandons any transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ws    <= '0;
      ch_rdata  <= '0;
      ch_rdy    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from pre-edge values regardless of statement order.
      case (r_state)
        IDLE: begin
          if (w_found) begin
            grant_id  <= w_idx;
            mem_addr  <= w_sel_addr;
            mem_wdata <= w_sel_wdata;
            mem_ws    <= w_sel_ws;
            mem_wr    <= w_sel_wr;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            r_state   <= MEM;
          end
        end

        MEM: begin
          // Latched fields stay constant; a write still returns mem_rdata.
          if (mem_rdy) begin
            ch_rdata <= mem_rdata;
            mem_req  <= 1'b0;
            ch_rdy   <= NCH'(1) << grant_id;
            r_state  <= RESP;
          end
        end

        RESP: begin
          // Completion pulse lasts exactly this one cycle.
          ch_rdy  <= '0;
          busy    <= 1'b0;
          r_ptr   <= GW'(next_idx(int'(grant_id), NCH));
          r_state <= IDLE;
        end

        default: begin
          mem_req <= 1'b0;
          ch_rdy  <= '0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Two 3-channel instances run in
// lock-step on shared timing inputs: one round-robin, one fixed priority.
// Each has its own set of masters; a transaction-level model predicts the
// winner, latched fields, completion pulse and returned data.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int GW  = $clog2(NCH);
  localparam int ND  = 2;   // index 0: round-robin, index 1: fixed priority

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NCH-1:0]    ch_req   [ND];
  logic [NCH-1:0]    ch_wr    [ND];
  logic [NCH*AW-1:0] ch_addr  [ND];
  logic [NCH*DW-1:0] ch_wdata [ND];
  logic [NCH*2-1:0]  ch_ws    [ND];
  logic [DW-1:0]     ch_rdata [ND];
  logic [NCH-1:0]    ch_rdy   [ND];
  logic              mem_req  [ND];
  logic              mem_wr   [ND];
  logic [AW-1:0]     mem_addr [ND];
  logic [DW-1:0]     mem_wdata[ND];
  logic [1:0]        mem_ws   [ND];
  logic [GW-1:0]     grant_id [ND];
  logic              busy     [ND];
  logic [DW-1:0]     mem_rdata;
  logic              mem_rdy;

  int    total = 0;
  int    bad   = 0;
  int    ptr [ND];
  string nm  [ND] = '{"rr", "fp"};

  mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .FIXED_PRIO(0)) u_rr (
    .clock(clock), .reset(reset),
    .ch_req(ch_req[0]), .ch_wr(ch_wr[0]), .ch_addr(ch_addr[0]),
    .ch_wdata(ch_wdata[0]), .ch_ws(ch_ws[0]),
    .ch_rdata(ch_rdata[0]), .ch_rdy(ch_rdy[0]),
    .mem_req(mem_req[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_ws(mem_ws[0]),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .grant_id(grant_id[0]), .busy(busy[0])
  );

  mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .FIXED_PRIO(1)) u_fp (
    .clock(clock), .reset(reset),
    .ch_req(ch_req[1]), .ch_wr(ch_wr[1]), .ch_addr(ch_addr[1]),
    .ch_wdata(ch_wdata[1]), .ch_ws(ch_ws[1]),
    .ch_rdata(ch_rdata[1]), .ch_rdy(ch_rdy[1]),
    .mem_req(mem_req[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_ws(mem_ws[1]),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .grant_id(grant_id[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic string t(input int d, input string s);
    return $sformatf("%s_%s", nm[d], s);
  endfunction

  // Reference rule: first requesting channel scanning upward from start, wrapping.
  function automatic int pick(input logic [NCH-1:0] r, input int start);
    for (int off = 0; off < NCH; off++)
      if (r[(start + off) % NCH]) return (start + off) % NCH;
    return -1;
  endfunction

  task automatic new_fields(input int d, input int c);
    ch_addr [d][c*AW +: AW] = $urandom;
    ch_wdata[d][c*DW +: DW] = $urandom;
    ch_ws   [d][c*2  +: 2]  = 2'($urandom_range(0, 2));
    ch_wr   [d][c]          = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all_zero(input string s);
    for (int d = 0; d < ND; d++) begin
      check(t(d, {s, "_mem_req"}),   mem_req[d],   0);
      check(t(d, {s, "_mem_wr"}),    mem_wr[d],    0);
      check(t(d, {s, "_mem_addr"}),  mem_addr[d],  0);
      check(t(d, {s, "_mem_wdata"}), mem_wdata[d], 0);
      check(t(d, {s, "_mem_ws"}),    mem_ws[d],    0);
      check(t(d, {s, "_ch_rdy"}),    ch_rdy[d],    0);
      check(t(d, {s, "_ch_rdata"}),  ch_rdata[d],  0);
      check(t(d, {s, "_grant"}),     grant_id[d],  0);
      check(t(d, {s, "_busy"}),      busy[d],      0);
    end
  endtask

  // Idle cycles with no requests; a stray mem_rdy on the first one must be ignored.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rdy   = (i == 0);
      mem_rdata = $urandom;
      @(negedge clock);
      for (int d = 0; d < ND; d++) begin
        check(t(d, "idle_mem_req"), mem_req[d], 0);
        check(t(d, "idle_ch_rdy"),  ch_rdy[d],  0);
        check(t(d, "idle_busy"),    busy[d],    0);
      end
    end
    mem_rdy = 1'b0;
  endtask

  // Master behaviour after completion. mode 0: served master re-requests,
  // mode 1: served master goes quiet, else random activity.
  task automatic update(input int d, input int g, input bit dropped, input int mode);
    case (mode)
      0: begin ch_req[d][g] = 1'b1; new_fields(d, g); end
      1: ch_req[d][g] = 1'b0;
      default: begin
        if (!dropped && $urandom_range(0, 1) == 1) new_fields(d, g);
        else ch_req[d][g] = 1'b0;
        for (int c = 0; c < NCH; c++)
          if (c != g && !ch_req[d][c] && $urandom_range(0, 2) == 0) begin
            ch_req[d][c] = 1'b1;
            new_fields(d, c);
          end
      end
    endcase
  endtask

  // One full transaction, entered and left at an IDLE-cycle falling edge.
  task automatic run_txn(input int k, input bit drop, input logic [DW-1:0] rd,
                         input int mode, input bit stray);
    int             g   [ND];
    logic [AW-1:0]  ea  [ND];
    logic [DW-1:0]  ew  [ND];
    logic [1:0]     es  [ND];
    logic           ewr [ND];
    logic [NCH-1:0] oh;
    for (int d = 0; d < ND; d++) begin
      g[d]   = pick(ch_req[d], (d == 1) ? 0 : ptr[d]);
      ea[d]  = ch_addr [d][g[d]*AW +: AW];
      ew[d]  = ch_wdata[d][g[d]*DW +: DW];
      es[d]  = ch_ws   [d][g[d]*2  +: 2];
      ewr[d] = ch_wr   [d][g[d]];
    end
    @(negedge clock);
    for (int d = 0; d < ND; d++) begin
      check(t(d, "mem_req_up"), mem_req[d],   1);
      check(t(d, "busy_mem"),   busy[d],      1);
      check(t(d, "grant"),      grant_id[d],  g[d]);
      check(t(d, "mem_addr"),   mem_addr[d],  ea[d]);
      check(t(d, "mem_wdata"),  mem_wdata[d], ew[d]);
      check(t(d, "mem_ws"),     mem_ws[d],    es[d]);
      check(t(d, "mem_wr"),     mem_wr[d],    ewr[d]);
      check(t(d, "rdy_early"),  ch_rdy[d],    0);
      if (drop) begin
        ch_req[d][g[d]] = 1'b0;
        ch_addr[d][g[d]*AW +: AW] = ~ea[d];
      end
    end
    for (int i = 0; i < k; i++) begin
      @(negedge clock);
      for (int d = 0; d < ND; d++) begin
        check(t(d, "mem_req_hold"),  mem_req[d],  1);
        check(t(d, "mem_addr_hold"), mem_addr[d], ea[d]);
        check(t(d, "rdy_wait"),      ch_rdy[d],   0);
      end
    end
    mem_rdata = rd;
    mem_rdy   = 1'b1;
    @(negedge clock);
    mem_rdy   = stray;
    mem_rdata = $urandom;
    for (int d = 0; d < ND; d++) begin
      oh = '0;
      oh[g[d]] = 1'b1;
      check(t(d, "ch_rdy"),     ch_rdy[d],   oh);
      check(t(d, "ch_rdata"),   ch_rdata[d], rd);
      check(t(d, "mem_req_dn"), mem_req[d],  0);
      check(t(d, "busy_resp"),  busy[d],     1);
    end
    @(negedge clock);
    mem_rdy = 1'b0;
    for (int d = 0; d < ND; d++) begin
      check(t(d, "rdy_pulse_end"), ch_rdy[d],  0);
      check(t(d, "busy_idle"),     busy[d],    0);
      check(t(d, "mem_req_idle"),  mem_req[d], 0);
      ptr[d] = (g[d] + 1) % NCH;
      update(d, g[d], drop, mode);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [NCH-1:0] saved [ND];
    int c;
    for (int d = 0; d < ND; d++) begin
      ch_req[d] = '0; ch_wr[d] = '0; ch_addr[d] = '0;
      ch_wdata[d] = '0; ch_ws[d] = '0; ptr[d] = 0;
    end
    mem_rdy   = 1'b0;
    mem_rdata = '0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("post_rst");

    // Single read from channel 0, memory answers after two wait cycles.
    for (int d = 0; d < ND; d++) begin
      ch_req[d] = 3'b001;
      new_fields(d, 0);
      ch_addr[d][0 +: AW] = 32'h100;
      ch_wr[d][0] = 1'b0;
    end
    run_txn(2, 1'b0, 32'hDEADBEEF, 1, 1'b0);
    idle_check(3);

    // Contention: all channels held, served master re-requests immediately.
    for (int d = 0; d < ND; d++) begin
      ch_req[d] = '1;
      for (int i = 0; i < NCH; i++) new_fields(d, i);
    end
    repeat (4) run_txn(0, 1'b0, $urandom, 0, 1'b0);
    // Served master goes quiet once; fixed priority then moves to channel 1.
    run_txn(0, 1'b0, $urandom, 1, 1'b0);
    run_txn(1, 1'b0, $urandom, 2, 1'b0);

    // Byte write from channel 1 passes through unchanged.
    for (int d = 0; d < ND; d++) begin
      ch_req[d] = 3'b010;
      ch_addr [d][1*AW +: AW] = 32'h2000;
      ch_wdata[d][1*DW +: DW] = 32'h55;
      ch_ws   [d][1*2  +: 2]  = WS_BYTE;
      ch_wr   [d][1]          = 1'b1;
    end
    run_txn(3, 1'b0, $urandom, 1, 1'b0);

    // Requester drops req mid-transaction; stray mem_rdy in RESP too.
    for (int d = 0; d < ND; d++) begin
      ch_req[d] = 3'b100;
      new_fields(d, 2);
    end
    run_txn(2, 1'b1, $urandom, 1, 1'b1);
    idle_check(2);

    // Reset while the memory request is outstanding.
    for (int d = 0; d < ND; d++) begin
      ch_req[d] = '1;
      for (int i = 0; i < NCH; i++) new_fields(d, i);
    end
    @(negedge clock);
    for (int d = 0; d < ND; d++) check(t(d, "pre_rst_mem_req"), mem_req[d], 1);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clock);
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      ptr[d] = 0;
      ch_req[d] = 3'b110;
    end
    run_txn(1, 1'b0, $urandom, 2, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < ND; d++)
        if (ch_req[d] == '0) begin
          c = $urandom_range(0, NCH - 1);
          ch_req[d][c] = 1'b1;
          new_fields(d, c);
        end
      if (n % 10 == 9) begin
        for (int d = 0; d < ND; d++) begin
          saved[d]  = ch_req[d];
          ch_req[d] = '0;
        end
        idle_check(2);
        for (int d = 0; d < ND; d++) ch_req[d] = saved[d];
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom, 2,
              $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
